spi_boot_master: RTL and testbench

Single-lane SPI master that drives the PULPino SPI-slave boot port (spi_clk_i, spi_cs_i, spi_sdi0_i, spi_sdo0_o) from FPGA fabric logic. Used to load and read back memory over the slave's standard-mode protocol without an external host.
- Converts one 32-bit word request into one SPI transaction: write command 0x02, read command 0x0B.
- Sits beside the SoC wrapper in the FPGA top level.

---
 rtl/spi_boot_master.sv | 152 +++++++++++++++
 tb/tb_spi_boot_master.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_boot_master.sv
// spi_boot_master: single-lane SPI mode-0 master driving the PULPino SPI-slave boot port.
// Define SPI_BOOT_MASTER_REG_EN to add req_reg_i for programming the slave dummy-cycle register.
module spi_boot_master #(
   parameter int CLK_DIV      = 2,
   parameter int DUMMY_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
`ifdef SPI_BOOT_MASTER_REG_EN
   input  logic        req_reg_i,
`endif
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_rdata_o,
   output logic        spi_clk_o,
   output logic        spi_csn_o,
   output logic        spi_sdo_o,
   input  logic        spi_sdi_i,
   output logic        busy_o
);
   typedef enum logic [3:0] {IDLE, CS_SETUP, CMD, ADDR, DATA_W, DUMMY, DATA_R, CS_HOLD, GAP} state_t;
   state_t      state;
   logic [7:0]  hcnt, dcnt, dummy_r, cmd;
   logic [5:0]  bcnt;
   logic [30:0] sh, rx;
   logic [31:0] addr_q, wdata_q;
   logic        write_q, reg_q, reg_in, wrap, rise, fall, bit_st;
`ifdef SPI_BOOT_MASTER_REG_EN
   assign reg_in = req_reg_i;
`else
   assign reg_in  = 1'b0;
   assign reg_q   = 1'b0;
   assign dummy_r = 8'(DUMMY_CYCLES);
`endif
   assign cmd    = reg_in ? 8'h11 : req_write_i ? 8'h02 : 8'h0B;
   assign wrap   = hcnt == 8'(CLK_DIV - 1);
   assign bit_st = state inside {CMD, ADDR, DATA_W, DUMMY, DATA_R};
   assign rise   = bit_st && wrap && !spi_clk_o;
   assign fall   = bit_st && wrap && spi_clk_o;
   // sh holds the bits still to be sent after the one currently on spi_sdo_o
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         hcnt         <= '0;
         dcnt         <= '0;
         bcnt         <= '0;
         sh           <= '0;
         rx           <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         write_q      <= 1'b0;
         req_ready_o  <= 1'b1;
         resp_valid_o <= 1'b0;
         resp_rdata_o <= '0;
         spi_clk_o    <= 1'b0;
         spi_csn_o    <= 1'b1;
         spi_sdo_o    <= 1'b0;
         busy_o       <= 1'b0;
`ifdef SPI_BOOT_MASTER_REG_EN
         reg_q        <= 1'b0;
         dummy_r      <= 8'(DUMMY_CYCLES);
`endif
      end else begin
         resp_valid_o <= 1'b0;
         hcnt <= (state == IDLE || wrap) ? '0 : hcnt + 8'd1;
         if (bit_st && wrap)
            spi_clk_o <= !spi_clk_o;
         if (fall) begin
            spi_sdo_o <= sh[30];
            sh        <= {sh[29:0], 1'b0};
            bcnt      <= bcnt + 6'd1;
         end
         case (state)
            IDLE: if (req_valid_i) begin
               addr_q      <= req_addr_i;
               wdata_q     <= req_wdata_i;
               write_q     <= req_write_i;
`ifdef SPI_BOOT_MASTER_REG_EN
               reg_q       <= req_reg_i;
`endif
               spi_csn_o   <= 1'b0;
               spi_sdo_o   <= cmd[7];
               sh          <= {cmd[6:0], 24'd0};
               req_ready_o <= 1'b0;
               busy_o      <= 1'b1;
               state       <= CS_SETUP;
            end
            CS_SETUP: if (wrap) begin
               bcnt  <= '0;
               state <= CMD;
            end
            CMD: if (fall && bcnt == 6'd7) begin
               bcnt      <= '0;
               state     <= reg_q ? DATA_W : ADDR;
               spi_sdo_o <= reg_q ? wdata_q[7] : addr_q[31];
               sh        <= reg_q ? {wdata_q[6:0], 24'd0} : addr_q[30:0];
            end
            ADDR: if (fall && bcnt == 6'd31) begin
               bcnt      <= '0;
               dcnt      <= '0;
               state     <= write_q ? DATA_W : DUMMY;
               spi_sdo_o <= write_q & wdata_q[31];
               sh        <= write_q ? wdata_q[30:0] : '0;
            end
            DATA_W: if (fall && bcnt == (reg_q ? 6'd7 : 6'd31)) begin
               spi_sdo_o <= 1'b0;
               sh        <= '0;
               state     <= CS_HOLD;
            end
            DUMMY: if (fall) begin
               bcnt <= '0;
               dcnt <= (dcnt == dummy_r - 8'd1) ? '0 : dcnt + 8'd1;
               if (dcnt == dummy_r - 8'd1)
                  state <= DATA_R;
            end
            DATA_R: begin
               if (rise) begin
                  rx <= {rx[29:0], spi_sdi_i};
                  if (bcnt == 6'd31)
                     resp_rdata_o <= {rx, spi_sdi_i};
               end
               if (fall && bcnt == 6'd31)
                  state <= CS_HOLD;
            end
            CS_HOLD: if (wrap) begin
               bcnt         <= '0;
               spi_csn_o    <= 1'b1;
               resp_valid_o <= 1'b1;
               state        <= GAP;
`ifdef SPI_BOOT_MASTER_REG_EN
               // a zero count would stall reads forever, so it is not adopted locally
               if (reg_q && wdata_q[7:0] != 8'd0)
                  dummy_r <= wdata_q[7:0];
`endif
            end
            GAP: if (wrap) begin
               bcnt <= (bcnt == 6'd1) ? '0 : bcnt + 6'd1;
               if (bcnt == 6'd1) begin
                  req_ready_o <= 1'b1;
                  busy_o      <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_boot_master.sv
// tb_spi_boot_master: scoreboard bench for spi_boot_master with a protocol-level SPI slave model.
// Two instances (CLK_DIV 2 and 1) share the slave model through the sel mux.
module tb_spi_boot_master;
   typedef struct {
      logic [7:0]  cmd;
      logic [31:0] addr;
      logic [31:0] data;
      int          nr;
      int          lat;
   } exp_t;
   typedef struct {
      logic [7:0]  cmd;
      logic [31:0] addr;
      logic [31:0] data;
      int          nr;
      int          pmin;
      int          pmax;
      int          gap;
   } obs_t;

   logic        clk = 0, rst = 1, sel = 0;
   logic        valid = 0, write = 0, reg_r = 0, sdi = 0;
   logic [31:0] addr = 0, wdata = 0;
   logic        rdy0, rv0, sclk0, csn0, sdo0, busy0, rdy1, rv1, sclk1, csn1, sdo1, busy1;
   logic [31:0] rd0, rd1;
   logic        ready, resp_valid, sclk, csn, sdo, busy;
   logic [31:0] rdata;
   int          tests = 0, fails = 0;
   exp_t        exp_q[$];
   obs_t        obs_q[$];

   assign ready      = sel ? rdy1 : rdy0;
   assign resp_valid = sel ? rv1 : rv0;
   assign sclk       = sel ? sclk1 : sclk0;
   assign csn        = sel ? csn1 : csn0;
   assign sdo        = sel ? sdo1 : sdo0;
   assign busy       = sel ? busy1 : busy0;
   assign rdata      = sel ? rd1 : rd0;

   always #5 clk = ~clk;

   spi_boot_master #(.CLK_DIV(2), .DUMMY_CYCLES(32)) dut (
      .clk(clk), .rst(rst), .req_valid_i(valid && !sel), .req_ready_o(rdy0), .req_write_i(write),
`ifdef SPI_BOOT_MASTER_REG_EN
      .req_reg_i(reg_r),
`endif
      .req_addr_i(addr), .req_wdata_i(wdata), .resp_valid_o(rv0), .resp_rdata_o(rd0),
      .spi_clk_o(sclk0), .spi_csn_o(csn0), .spi_sdo_o(sdo0), .spi_sdi_i(sdi), .busy_o(busy0));

   spi_boot_master #(.CLK_DIV(1), .DUMMY_CYCLES(32)) dut1 (
      .clk(clk), .rst(rst), .req_valid_i(valid && sel), .req_ready_o(rdy1), .req_write_i(write),
`ifdef SPI_BOOT_MASTER_REG_EN
      .req_reg_i(reg_r),
`endif
      .req_addr_i(addr), .req_wdata_i(wdata), .resp_valid_o(rv1), .resp_rdata_o(rd1),
      .spi_clk_o(sclk1), .spi_csn_o(csn1), .spi_sdo_o(sdo1), .spi_sdi_i(sdi), .busy_o(busy1));

   // slave model: captures MOSI on SCLK rise, drives MISO after SCLK fall
   logic [7:0]  m_cmd = 0, s_dummy = 8'd32;
   logic [31:0] m_addr = 0, m_data = 0, m_word = 0;
   logic [31:0] mem [logic [31:0]];
   logic        p_sclk = 0, p_csn = 1;
   int          m_nr = 0, cyc = 0, last_rise = -1, pmin = 0, pmax = 0, gap = 0, cur_gap = 0, resp_cnt = 0;

   always @(negedge clk) begin
      cyc++;
      if (resp_valid) resp_cnt++;
      if (p_csn && !csn) begin
         m_nr = 0; m_cmd = 0; m_addr = 0; m_data = 0;
         last_rise = -1; pmin = 1 << 30; pmax = 0; cur_gap = gap;
      end
      if (!csn && sclk && !p_sclk) begin
         m_nr++;
         if (m_nr <= 8) m_cmd = {m_cmd[6:0], sdo};
         else if (m_cmd == 8'h11) m_data = {m_data[30:0], sdo};
         else if (m_nr <= 40) m_addr = {m_addr[30:0], sdo};
         else if (m_cmd == 8'h02) m_data = {m_data[30:0], sdo};
         if (last_rise >= 0) begin
            if (cyc - last_rise < pmin) pmin = cyc - last_rise;
            if (cyc - last_rise > pmax) pmax = cyc - last_rise;
         end
         last_rise = cyc;
      end
      if (!csn && !sclk && p_sclk && m_cmd == 8'h0B && m_nr >= 40 + int'(s_dummy) && m_nr < 72 + int'(s_dummy)) begin
         if (m_nr == 40 + int'(s_dummy)) m_word = mem.exists(m_addr) ? mem[m_addr] : 32'h0;
         sdi = m_word[71 + int'(s_dummy) - m_nr];
      end
      if (!p_csn && csn) begin
         obs_q.push_back('{m_cmd, m_addr, m_data, m_nr, pmin, pmax, cur_gap});
         if (m_cmd == 8'h02 && m_nr == 72) mem[m_addr] = m_data;
         if (m_cmd == 8'h11 && m_nr == 16 && m_data[7:0] != 8'd0) s_dummy = m_data[7:0];
         sdi = 0;
      end
      gap = csn ? gap + 1 : 0;
      p_csn = csn;
      p_sclk = sclk;
   end

   task automatic do_req(input logic wr, input logic rg, input logic [31:0] a, input logic [31:0] d, output int lat);
      int n;
      @(negedge clk);
      write = wr; reg_r = rg; addr = a; wdata = d; valid = 1;
      n = 0;
      while (!ready && n < 1000) begin @(negedge clk); n++; end
      @(posedge clk);
      #1 valid = 0;
      lat = 0;
      do begin @(posedge clk); #1 lat++; end while (!resp_valid && lat < 5000);
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset;
      int n, r0;
      if (csn !== 1'b1 || sclk !== 1'b0 || sdo !== 1'b0) begin fails++; $display("FAIL reset_spi_pins: got csn %b sclk %b sdo %b expected 1 0 0", csn, sclk, sdo); end
      tests++;
      if (ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL reset_handshake: got ready %b busy %b expected 1 0", ready, busy); end
      tests++;
      if (resp_valid !== 1'b0 || rdata !== 32'h0) begin fails++; $display("FAIL reset_resp: got valid %b rdata %h expected 0 00000000", resp_valid, rdata); end
      tests++;
      @(negedge clk);
      write = 1; addr = 32'h0000_0040; wdata = 32'h1111_2222; valid = 1;
      @(posedge clk);
      #1 valid = 0;
      n = 0;
      while (m_nr < 12 && n < 2000) begin @(posedge clk); n++; end
      r0 = resp_cnt;
      #3 rst = 1;
      #1;
      if (csn !== 1'b1 || sclk !== 1'b0 || sdo !== 1'b0) begin fails++; $display("FAIL midreset_spi_pins: got csn %b sclk %b sdo %b expected 1 0 0", csn, sclk, sdo); end
      tests++;
      if (ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL midreset_handshake: got ready %b busy %b expected 1 0", ready, busy); end
      tests++;
      repeat (3) @(negedge clk);
      rst = 0;
      repeat (4) @(negedge clk);
      if (resp_cnt != r0) begin fails++; $display("FAIL midreset_no_resp: got %0d pulses expected %0d", resp_cnt, r0); end
      tests++;
      obs_q.delete();
   endtask

   task automatic test_write;
      exp_t e; obs_t o; int lat, r0;
      exp_q.push_back('{8'h02, 32'h1A10_0000, 32'hDEAD_BEEF, 72, (1 + 144 + 1) * 2});
      r0 = resp_cnt;
      do_req(1'b1, 1'b0, 32'h1A10_0000, 32'hDEAD_BEEF, lat);
      e = exp_q.pop_front();
      if (lat != e.lat) begin fails++; $display("FAIL write_latency: got %0d expected %0d", lat, e.lat); end
      tests++;
      if (resp_cnt != r0 + 1) begin fails++; $display("FAIL write_resp_count: got %0d expected %0d", resp_cnt - r0, 1); end
      tests++;
      if (obs_q.size() != 1) begin fails++; $display("FAIL write_frames: got %0d expected 1", obs_q.size()); end
      else begin
         o = obs_q.pop_front();
         if (o.cmd !== e.cmd || o.addr !== e.addr || o.data !== e.data || o.nr != e.nr) begin
            fails++;
            $display("FAIL write_frame: got cmd %h addr %h data %h rises %0d expected cmd %h addr %h data %h rises %0d", o.cmd, o.addr, o.data, o.nr, e.cmd, e.addr, e.data, e.nr);
         end
         tests++;
      end
      tests++;
   endtask

   task automatic test_read;
      exp_t e; obs_t o; int lat;
      exp_q.push_back('{8'h0B, 32'h0000_0080, 32'h1234_5678, 8 + 32 + 32 + 32, (1 + 80 + 2 * 32 + 64 + 1) * 2});
      do_req(1'b0, 1'b0, 32'h0000_0080, 32'h0, lat);
      e = exp_q.pop_front();
      if (rdata !== e.data) begin fails++; $display("FAIL read_data: got %h expected %h", rdata, e.data); end
      tests++;
      if (lat != e.lat) begin fails++; $display("FAIL read_latency: got %0d expected %0d", lat, e.lat); end
      tests++;
      if (obs_q.size() != 1) begin fails++; $display("FAIL read_frames: got %0d expected 1", obs_q.size()); end
      else begin
         o = obs_q.pop_front();
         if (o.cmd !== e.cmd || o.addr !== e.addr || o.nr != e.nr) begin
            fails++;
            $display("FAIL read_frame: got cmd %h addr %h rises %0d expected cmd %h addr %h rises %0d", o.cmd, o.addr, o.nr, e.cmd, e.addr, e.nr);
         end
         tests++;
      end
      tests++;
   endtask

   task automatic test_back_to_back;
      exp_t e; obs_t o; int n, k, lat, r0;
      exp_q.push_back('{8'h02, 32'h0000_0100, 32'hCAFE_F00D, 72, 0});
      exp_q.push_back('{8'h02, 32'h0000_0104, 32'h0BAD_5EED, 72, 0});
      r0 = resp_cnt;
      @(negedge clk);
      write = 1; addr = 32'h0000_0100; wdata = 32'hCAFE_F00D; valid = 1;
      n = 0;
      while (!ready && n < 1000) begin @(negedge clk); n++; end
      @(posedge clk);
      #1 addr = 32'h0000_0104; wdata = 32'h0BAD_5EED;
      lat = 0;
      do begin @(posedge clk); #1 lat++; end while (!resp_valid && lat < 5000);
      k = 0;
      while (!ready && k < 100) begin @(posedge clk); #1 k++; end
      if (k != 4) begin fails++; $display("FAIL b2b_resp_to_ready: got %0d cycles expected 4", k); end
      tests++;
      @(posedge clk);
      #1 valid = 0;
      if (busy !== 1'b1) begin fails++; $display("FAIL b2b_second_accept: got busy %b expected 1", busy); end
      tests++;
      lat = 0;
      do begin @(posedge clk); #1 lat++; end while (!resp_valid && lat < 5000);
      @(negedge clk);
      #1;
      if (resp_cnt != r0 + 2) begin fails++; $display("FAIL b2b_resp_count: got %0d expected 2", resp_cnt - r0); end
      tests++;
      if (obs_q.size() != 2) begin fails++; $display("FAIL b2b_frames: got %0d expected 2", obs_q.size()); end
      else for (int i = 0; i < 2; i++) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         if (o.cmd !== e.cmd || o.addr !== e.addr || o.data !== e.data || o.nr != e.nr) begin
            fails++;
            $display("FAIL b2b_frame%0d: got cmd %h addr %h data %h rises %0d expected cmd %h addr %h data %h rises %0d", i, o.cmd, o.addr, o.data, o.nr, e.cmd, e.addr, e.data, e.nr);
         end
         tests++;
         if (i == 1 && o.gap < 4) begin fails++; $display("FAIL b2b_csn_gap: got %0d cycles expected at least 4", o.gap); end
         if (i == 1) tests++;
      end
      tests++;
      exp_q.delete();
   endtask

   task automatic test_clk_div1;
      exp_t e; obs_t o; int lat;
      @(negedge clk);
      sel = 1;
      exp_q.push_back('{8'h0B, 32'h0000_0200, 32'hA5A5_5A5A, 104, 1 + 80 + 2 * 32 + 64 + 1});
      do_req(1'b0, 1'b0, 32'h0000_0200, 32'h0, lat);
      e = exp_q.pop_front();
      if (rdata !== e.data) begin fails++; $display("FAIL div1_data: got %h expected %h", rdata, e.data); end
      tests++;
      if (lat != e.lat) begin fails++; $display("FAIL div1_latency: got %0d expected %0d", lat, e.lat); end
      tests++;
      if (obs_q.size() != 1) begin fails++; $display("FAIL div1_frames: got %0d expected 1", obs_q.size()); end
      else begin
         o = obs_q.pop_front();
         if (o.pmin != 2 || o.pmax != 2 || o.nr != e.nr) begin
            fails++;
            $display("FAIL div1_sclk: got period %0d..%0d rises %0d expected period 2..2 rises %0d", o.pmin, o.pmax, o.nr, e.nr);
         end
         tests++;
      end
      tests++;
      repeat (4) @(negedge clk);
      sel = 0;
   endtask

`ifdef SPI_BOOT_MASTER_REG_EN
   task automatic test_reg;
      exp_t e; obs_t o; int lat;
      exp_q.push_back('{8'h11, 32'h0, 32'h0000_0008, 16, (1 + 32 + 1) * 2});
      do_req(1'b1, 1'b1, 32'h0, 32'h0000_0008, lat);
      e = exp_q.pop_front();
      if (lat != e.lat) begin fails++; $display("FAIL reg_latency: got %0d expected %0d", lat, e.lat); end
      tests++;
      if (obs_q.size() != 1) begin fails++; $display("FAIL reg_frames: got %0d expected 1", obs_q.size()); end
      else begin
         o = obs_q.pop_front();
         if (o.cmd !== e.cmd || o.data !== e.data || o.nr != e.nr) begin
            fails++;
            $display("FAIL reg_frame: got cmd %h data %h rises %0d expected cmd %h data %h rises %0d", o.cmd, o.data, o.nr, e.cmd, e.data, e.nr);
         end
         tests++;
      end
      tests++;
      exp_q.push_back('{8'h0B, 32'h0000_0080, 32'h1234_5678, 8 + 32 + 8 + 32, (1 + 80 + 2 * 8 + 64 + 1) * 2});
      do_req(1'b0, 1'b0, 32'h0000_0080, 32'h0, lat);
      e = exp_q.pop_front();
      if (rdata !== e.data || lat != e.lat) begin fails++; $display("FAIL reg_read: got data %h latency %0d expected data %h latency %0d", rdata, lat, e.data, e.lat); end
      tests++;
      if (obs_q.size() != 1) begin fails++; $display("FAIL reg_read_frames: got %0d expected 1", obs_q.size()); end
      else begin
         o = obs_q.pop_front();
         if (o.nr != e.nr) begin fails++; $display("FAIL reg_read_rises: got %0d expected %0d", o.nr, e.nr); end
         tests++;
      end
      tests++;
      // zero is sent to the slave but must not change the local turnaround count
      do_req(1'b0, 1'b1, 32'h0, 32'h0, lat);
      obs_q.delete();
      do_req(1'b0, 1'b0, 32'h0000_0080, 32'h0, lat);
      if (rdata !== 32'h1234_5678 || lat != (1 + 80 + 2 * 8 + 64 + 1) * 2) begin fails++; $display("FAIL reg_zero_ignored: got data %h latency %0d expected data 12345678 latency %0d", rdata, lat, (1 + 80 + 2 * 8 + 64 + 1) * 2); end
      tests++;
      obs_q.delete();
   endtask
`endif

   initial begin
      mem[32'h0000_0080] = 32'h1234_5678;
      mem[32'h0000_0200] = 32'hA5A5_5A5A;
      repeat (3) @(posedge clk);
      #1;
      test_reset;
      test_write;
      test_read;
      test_back_to_back;
      test_clk_div1;
`ifdef SPI_BOOT_MASTER_REG_EN
      test_reg;
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
